mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles to wait for mem_ack before reporting a bus error; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  64  byte address.
REQ-008 req_wdata  input  64  store data, right-aligned.
REQ-009 req_width  input  3  000 none, 001 d, 010 w, 011 h, 100 b, 101 wu, 110 hu, 111 bu.
REQ-010 mem_req  output  1  bus request, held until acknowledged.
REQ-011 mem_addr  output  64  {req_addr[63:3], 3'b000}.
REQ-012 mem_wen  output  1  bus write enable.
REQ-013 mem_wmask  output  8  byte-lane write mask.
REQ-014 mem_wdata  output  64  store data shifted to its byte lanes.
REQ-015 mem_ack  input  1  bus completes the current transfer; mem_rdata is valid in the same cycle.
REQ-016 mem_rdata  input  64  aligned 64-bit read word.
REQ-017 resp_valid  output  1  single-cycle completion pulse.
REQ-018 resp_data  output  64  extended load result; 0 for stores, errors and width 000.
REQ-019 resp_err  output  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal store width.

Function
REQ-020 The FSM SHALL use three states: IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on the clock edge where req_valid and req_ready are both 1; all request fields SHALL be latched on that edge.
REQ-022 From IDLE on accept: a legal access SHALL go to BUS; width 000, a misaligned access or an illegal store SHALL go directly to RESP with no bus activity.
REQ-023 An access is misaligned when: d and addr[2:0]!=0; w/wu and addr[1:0]!=0; h/hu and addr[0]!=0.
REQ-024 A store with width 101, 110 or 111 SHALL be illegal and SHALL report resp_err 11.
REQ-025 In BUS, mem_req SHALL be 1, and mem_addr, mem_wen, mem_wmask and mem_wdata SHALL be stable until the cycle in which mem_ack is 1.
REQ-026 Store mask SHALL be: d 0xFF; w 0x0F<<addr[2]*4; h 0x03<<addr[2:1]*2; b 0x01<<addr[2:0]; mem_wdata SHALL be req_wdata shifted left by addr[2:0]*8.
REQ-027 For loads, mem_wen and mem_wmask SHALL be 0.
REQ-028 On mem_ack in BUS, a load SHALL select the addressed lanes of mem_rdata, sign-extend for d/w/h/b and zero-extend for wu/hu/bu, register the result into resp_data, and go to RESP.
REQ-029 A BUS cycle counter SHALL clear on entry to BUS and increment on each cycle without mem_ack; when it reaches TIMEOUT without mem_ack, the FSM SHALL drop mem_req, go to RESP with resp_err 10 and resp_data 0.
REQ-030 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and the response SHALL be ok.
REQ-031 In RESP, resp_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-032 Latency SHALL be as follows: a bus access accepted at edge N drives mem_req from cycle N+1; with ack in cycle N+k, resp_valid is in cycle N+k+1. A non-bus response is in cycle N+1.
REQ-033 mem_ack outside BUS SHALL be ignored.
REQ-034 resp_data and resp_err SHALL hold their values until the next RESP.

Reset
REQ-035 While rstn is 0, the FSM SHALL be in IDLE and the counter SHALL be 0; req_ready SHALL be 1 once rstn is deasserted; mem_req, mem_wen, mem_wmask, mem_wdata, mem_addr, resp_valid, resp_data and resp_err SHALL be 0.
REQ-036 Reset asserted mid-BUS or mid-RESP SHALL abort the transfer immediately with no resp_valid pulse.

Verification
REQ-037 lb at addr 0x1003, mem_rdata 0x0000_0000_8000_0000, ack after 2 cycles -> resp_data 0xFFFF_FFFF_FFFF_FF80, resp_err 00, resp_valid 3 cycles after accept.
REQ-038 sh at addr 0x2006, wdata 0xABCD -> mem_wmask 0xC0, mem_wdata 0xABCD_0000_0000_0000, mem_addr 0x2000, mem_wen 1.
REQ-039 lw at addr 0x1002 -> no mem_req, resp_err 01, resp_data 0, resp_valid one cycle after accept.
REQ-040 ld with mem_ack never asserted and TIMEOUT 4 -> mem_req drops after 4 cycles, resp_err 10.
REQ-041 sbu store (width 111) -> resp_err 11 with no bus activity; lwu at 0x1004 with rdata 0x8000_0000_0000_0000 -> resp_data 0x0000_0000_8000_0000.
REQ-042 rstn pulsed low during BUS -> mem_req is 0 immediately, no resp_valid pulse, and req_ready is 1 after release.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_ctrl: load/store unit bridging pipeline requests to a 64-bit  |
// | aligned memory bus with lane steering, extension and bus timeout.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_width,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic [1:0]  resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_D    = 3'b001;
  localparam logic [2:0] W_W    = 3'b010;
  localparam logic [2:0] W_H    = 3'b011;
  localparam logic [2:0] W_B    = 3'b100;
  localparam logic [2:0] W_WU   = 3'b101;
  localparam logic [2:0] W_HU   = 3'b110;
  localparam logic [2:0] W_BU   = 3'b111;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  width_q, width_d;
  logic        mem_req_q, mem_req_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic        mem_wen_q, mem_wen_d;
  logic [7:0]  mem_wmask_q, mem_wmask_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic [1:0]  resp_err_q, resp_err_d;

  logic        misaligned;
  logic        illegal_store;
  logic [7:0]  store_mask;
  logic [63:0] load_result;

  function automatic logic [63:0] load_ext(input logic [63:0] rdata,
                                           input logic [2:0]  lo,
                                           input logic [2:0]  width);
    logic [63:0] sh;
    sh = rdata >> {lo, 3'b000};
    case (width)
      W_D:     load_ext = sh;
      W_W:     load_ext = {{32{sh[31]}}, sh[31:0]};
      W_H:     load_ext = {{48{sh[15]}}, sh[15:0]};
      W_B:     load_ext = {{56{sh[7]}}, sh[7:0]};
      W_WU:    load_ext = {32'd0, sh[31:0]};
      W_HU:    load_ext = {48'd0, sh[15:0]};
      W_BU:    load_ext = {56'd0, sh[7:0]};
      default: load_ext = 64'd0;
    endcase
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (req_width)
      W_D:        misaligned = (req_addr[2:0] != 3'b000);
      W_W, W_WU:  misaligned = (req_addr[1:0] != 2'b00);
      W_H, W_HU:  misaligned = req_addr[0];
      default:    misaligned = 1'b0;
    endcase
  end

  // Unsigned widths have no meaning for stores.
  assign illegal_store = req_we && req_width[2] && (req_width[1:0] != 2'b00);

  always_comb begin
    store_mask = 8'h00;
    case (req_width)
      W_D:     store_mask = 8'hFF;
      W_W:     store_mask = 8'h0F << {req_addr[2], 2'b00};
      W_H:     store_mask = 8'h03 << {req_addr[2:1], 1'b0};
      W_B:     store_mask = 8'h01 << req_addr[2:0];
      default: store_mask = 8'h00;
    endcase
  end

  assign load_result = load_ext(mem_rdata, addr_lo_q, width_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_lo_d    = addr_lo_q;
    width_d      = width_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wen_d    = mem_wen_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          addr_lo_d = req_addr[2:0];
          width_d   = req_width;
          if (req_width == W_NONE || misaligned || illegal_store) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = 64'd0;
            resp_err_d   = illegal_store ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
          end else begin
            state_d     = BUS;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {req_addr[63:3], 3'b000};
            mem_wen_d   = req_we;
            mem_wmask_d = req_we ? store_mask : 8'h00;
            mem_wdata_d = req_we ? (req_wdata << {req_addr[2:0], 3'b000}) : 64'd0;
          end
        end
      end
      BUS: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          mem_wen_d    = 1'b0;
          mem_wmask_d  = 8'h00;
          resp_valid_d = 1'b1;
          resp_err_d   = 2'b00;
          resp_data_d  = we_q ? 64'd0 : load_result;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          mem_wen_d    = 1'b0;
          mem_wmask_d  = 8'h00;
          resp_valid_d = 1'b1;
          resp_err_d   = 2'b10;
          resp_data_d  = 64'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      we_q         <= 1'b0;
      addr_lo_q    <= 3'd0;
      width_q      <= 3'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wen_q    <= 1'b0;
      mem_wmask_q  <= 8'h00;
      mem_wdata_q  <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 64'd0;
      resp_err_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_lo_q    <= addr_lo_d;
      width_q      <= width_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wen    = mem_wen_q;
  assign mem_wmask  = mem_wmask_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_width = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;

  int n_vec = 0;
  int n_err = 0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for the accept edge; returns 1ns into cycle N+1.
  task automatic send(input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [2:0] width);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_width = width;
    chk("ready_before_accept", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_mem_req",    64'(mem_req), 64'd0);
    chk("rst_mem_addr",   mem_addr, 64'd0);
    chk("rst_mem_wmask",  64'(mem_wmask), 64'd0);
    chk("rst_mem_wdata",  mem_wdata, 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data",  resp_data, 64'd0);
    chk("rst_resp_err",   64'(resp_err), 64'd0);
    step();
    rstn = 1'b1;
    step();
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // lb 0x1003, ack in N+2
    send(1'b0, 64'h1003, 64'd0, 3'b100);
    chk("lb_mem_req",   64'(mem_req), 64'd1);
    chk("lb_mem_addr",  mem_addr, 64'h1000);
    chk("lb_mem_wen",   64'(mem_wen), 64'd0);
    chk("lb_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("lb_ready_busy", 64'(req_ready), 64'd0);
    step();
    mem_ack = 1'b1;
    mem_rdata = 64'h0000_0000_8000_0000;
    step();
    mem_ack = 1'b0;
    chk("lb_resp_valid", 64'(resp_valid), 64'd1);
    chk("lb_resp_data",  resp_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_resp_err",   64'(resp_err), 64'd0);
    chk("lb_mem_req_drop", 64'(mem_req), 64'd0);
    step();
    chk("lb_pulse_single", 64'(resp_valid), 64'd0);
    chk("lb_data_hold",    resp_data, 64'hFFFF_FFFF_FFFF_FF80);

    // sh 0x2006, ack in N+2 after a stall cycle
    send(1'b1, 64'h2006, 64'hABCD, 3'b011);
    chk("sh_mem_req",   64'(mem_req), 64'd1);
    chk("sh_mem_wmask", 64'(mem_wmask), 64'hC0);
    chk("sh_mem_wdata", mem_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_mem_addr",  mem_addr, 64'h2000);
    chk("sh_mem_wen",   64'(mem_wen), 64'd1);
    step();
    chk("sh_stable_wmask", 64'(mem_wmask), 64'hC0);
    chk("sh_stable_req",   64'(mem_req), 64'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sh_resp_valid", 64'(resp_valid), 64'd1);
    chk("sh_resp_data",  resp_data, 64'd0);
    chk("sh_resp_err",   64'(resp_err), 64'd0);
    step();

    // lw misaligned
    send(1'b0, 64'h1002, 64'd0, 3'b010);
    chk("lw_mis_mem_req", 64'(mem_req), 64'd0);
    chk("lw_mis_valid",   64'(resp_valid), 64'd1);
    chk("lw_mis_err",     64'(resp_err), 64'd1);
    chk("lw_mis_data",    resp_data, 64'd0);
    step();
    chk("lw_mis_err_hold", 64'(resp_err), 64'd1);

    // mem_ack in IDLE must be ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_ignored", 64'(resp_valid), 64'd0);

    // ld, ack in N+4 collides with the last counted cycle: ack wins
    send(1'b0, 64'h4000, 64'd0, 3'b001);
    step(); step(); step();
    chk("ld_edge_req", 64'(mem_req), 64'd1);
    mem_ack = 1'b1;
    mem_rdata = 64'h1122_3344_5566_7788;
    step();
    mem_ack = 1'b0;
    chk("ld_edge_valid", 64'(resp_valid), 64'd1);
    chk("ld_edge_err",   64'(resp_err), 64'd0);
    chk("ld_edge_data",  resp_data, 64'h1122_3344_5566_7788);
    step();

    // ld timeout, TIMEOUT=4
    send(1'b0, 64'h3000, 64'd0, 3'b001);
    step(); step(); step();
    chk("to_req_cycle4", 64'(mem_req), 64'd1);
    chk("to_no_early_resp", 64'(resp_valid), 64'd0);
    step();
    chk("to_req_drop", 64'(mem_req), 64'd0);
    chk("to_valid",    64'(resp_valid), 64'd1);
    chk("to_err",      64'(resp_err), 64'd2);
    chk("to_data",     resp_data, 64'd0);
    step();

    // sbu: illegal store width
    send(1'b1, 64'h1000, 64'h55, 3'b111);
    chk("sbu_mem_req", 64'(mem_req), 64'd0);
    chk("sbu_valid",   64'(resp_valid), 64'd1);
    chk("sbu_err",     64'(resp_err), 64'd3);
    step();

    // lwu 0x1004, ack in N+1
    send(1'b0, 64'h1004, 64'd0, 3'b101);
    mem_ack = 1'b1;
    mem_rdata = 64'h8000_0000_0000_0000;
    step();
    mem_ack = 1'b0;
    chk("lwu_valid", 64'(resp_valid), 64'd1);
    chk("lwu_data",  resp_data, 64'h0000_0000_8000_0000);
    chk("lwu_err",   64'(resp_err), 64'd0);
    step();

    // lh 0x5002 sign-extended, lhu same word zero-extended
    send(1'b0, 64'h5002, 64'd0, 3'b011);
    mem_ack = 1'b1;
    mem_rdata = 64'h0000_0000_ABCD_0000;
    step();
    mem_ack = 1'b0;
    chk("lh_data", resp_data, 64'hFFFF_FFFF_FFFF_ABCD);
    step();
    send(1'b0, 64'h5002, 64'd0, 3'b110);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lhu_data", resp_data, 64'h0000_0000_0000_ABCD);
    step();

    // sw upper word mask
    send(1'b1, 64'h6004, 64'h1234_5678, 3'b010);
    chk("sw_mem_wmask", 64'(mem_wmask), 64'hF0);
    chk("sw_mem_wdata", mem_wdata, 64'h1234_5678_0000_0000);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();

    // width 000: immediate ok response with zero data
    send(1'b0, 64'h7000, 64'd0, 3'b000);
    chk("none_mem_req", 64'(mem_req), 64'd0);
    chk("none_valid",   64'(resp_valid), 64'd1);
    chk("none_err",     64'(resp_err), 64'd0);
    step();

    // reset during BUS
    send(1'b0, 64'h8000, 64'd0, 3'b001);
    chk("rb_mem_req", 64'(mem_req), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rb_req_async_drop", 64'(mem_req), 64'd0);
    chk("rb_no_valid",       64'(resp_valid), 64'd0);
    step();
    #2;
    rstn = 1'b1;
    step();
    chk("rb_ready_after", 64'(req_ready), 64'd1);
    chk("rb_no_valid_after", 64'(resp_valid), 64'd0);
    step();
    chk("rb_still_no_valid", 64'(resp_valid), 64'd0);
    chk("rb_mem_req_idle",   64'(mem_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
